// File: rtl/ysyx_23060075_lsu_axil.sv
// Load/store bridge: runs one word-aligned memory request as a single AXI4-Lite
// read or write transaction and returns the raw word or write status to the core.
module ysyx_23060075_lsu_axil #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [MASK_WIDTH-1:0] req_mask,
  input  logic                  req_r_en,
  input  logic                  req_w_en,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [MASK_WIDTH-1:0] wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, RESP} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [MASK_WIDTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  aw_done, w_done;
  logic                  accept, aw_hs, w_hs;

  assign req_ready  = (state == IDLE) & ~rst;
  assign accept     = req_valid & req_ready;
  assign arvalid    = (state == RD_A);
  assign rready     = (state == RD_D);
  assign awvalid    = (state == WR_AW) & ~aw_done;
  assign wvalid     = (state == WR_AW) & ~w_done;
  assign bready     = (state == WR_B);
  assign resp_valid = (state == RESP);
  assign aw_hs      = awvalid & awready;
  assign w_hs       = wvalid & wready;
  assign araddr     = addr_q;
  assign awaddr     = addr_q;
  assign wdata      = data_q;
  assign wstrb      = mask_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_r_en && !req_w_en)      state_next = RD_A;
          else if (req_w_en && !req_r_en) state_next = WR_AW;
          else                            state_next = RESP;
        end
      end
      RD_A:  if (arready) state_next = RD_D;
      RD_D:  if (rvalid)  state_next = RESP;
      // AW and W may finish in either order; leave once both have been seen.
      WR_AW: if ((aw_done | aw_hs) && (w_done | w_hs)) state_next = WR_B;
      WR_B:  if (bvalid) state_next = RESP;
      RESP:  if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      // Illegal (load+store) requests report an error without touching the bus.
      if (accept) begin
        addr_q  <= req_addr;
        data_q  <= req_wdata;
        mask_q  <= req_mask;
        rdata_q <= '0;
        err_q   <= req_r_en & req_w_en;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == WR_AW) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (state == RD_D && rvalid) begin
        rdata_q <= rdata;
        err_q   <= (rresp != 2'b00);
      end
      if (state == WR_B && bvalid) begin
        rdata_q <= '0;
        err_q   <= (bresp != 2'b00);
      end
    end
  end

endmodule
